// File: rtl/fp_pkg.sv
// Shared constants and FSM states for the single-precision add/sub post-processing datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Bit offsets of the fields inside a packed IEEE-754 single word
    localparam int SIGN_POS = 31;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SHIFT = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even increment; shared with the multiplier datapath.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int SIG_W = FRAC_W + 1
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             guard,
    input  logic             sticky,
    output logic [SIG_W-1:0] sig_rnd,
    output logic             carry
);

    logic inc;

    // Ties (guard set, sticky clear) round up only when the LSB is odd
    assign inc = guard & (sticky | sig[0]);
    assign {carry, sig_rnd} = {1'b0, sig} + {{SIG_W{1'b0}}, inc};

endmodule

// File: rtl/fp_norm_round_pack.sv
// Multi-cycle normalise / round-nearest-even / pack stage for the FP adder.
// Optional FP_NORM_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
module fp_norm_round_pack #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_sig,
    input  logic              in_guard,
    input  logic              in_sticky,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic              out_zero
`ifdef FP_NORM_FLAGS_EN
    ,
    output logic [2:0]        out_flags
`endif
);

    import fp_pkg::*;

    localparam int SIG_W = FRAC_W + 2;
    localparam logic [EXP_W:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_ALL1 = {1'b0, {EXP_W{1'b1}}};

    state_t            state;
    logic              sign_r;
    logic              guard_r;
    logic              sticky_r;
    logic [EXP_W:0]    exp_r;
    logic [SIG_W-1:0]  sig_r;

    logic [FRAC_W:0]   rnd_sig;
    logic              rnd_carry;
    logic [EXP_W:0]    exp_rnd;
    logic [FRAC_W-1:0] frac_rnd;

    // Packs sign/exp/frac, saturating to infinity once the exponent reaches all-ones
    function automatic logic [31:0] sat_pack(input logic s, input logic [EXP_W:0] e,
                                             input logic [FRAC_W-1:0] f);
        logic [31:0] w;
        w = '0;
        w[SIGN_POS] = s;
        if (e >= EXP_ALL1) begin
            w[EXP_LSB +: EXP_W] = {EXP_W{1'b1}};
        end else begin
            w[EXP_LSB +: EXP_W]   = e[EXP_W-1:0];
            w[FRAC_LSB +: FRAC_W] = f;
        end
        return w;
    endfunction

    fp_round_rne #(.SIG_W(FRAC_W + 1)) u_round (
        .sig     (sig_r[FRAC_W:0]),
        .guard   (guard_r),
        .sticky  (sticky_r),
        .sig_rnd (rnd_sig),
        .carry   (rnd_carry)
    );

    // A rounding carry leaves rnd_sig all-zero, so the renormalised fraction is zero either way
    always_comb begin
        exp_rnd  = exp_r + {{EXP_W{1'b0}}, rnd_carry};
        frac_rnd = rnd_carry ? rnd_sig[FRAC_W:1] : rnd_sig[FRAC_W-1:0];
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
            exp_r     <= '0;
            sig_r     <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_zero  <= 1'b0;
`ifdef FP_NORM_FLAGS_EN
            out_flags <= 3'b000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r   <= in_sign;
                        exp_r    <= {1'b0, in_exp};
                        sig_r    <= in_sig;
                        guard_r  <= in_guard;
                        sticky_r <= in_sticky;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (sig_r == '0) begin
                        out_word <= sat_pack(sign_r, '0, '0);
                        out_zero <= 1'b1;
`ifdef FP_NORM_FLAGS_EN
                        out_flags <= 3'b000;
`endif
                        state    <= DONE;
                    end else if (sig_r[SIG_W-1]) begin
                        sig_r    <= sig_r >> 1;
                        guard_r  <= sig_r[0];
                        sticky_r <= sticky_r | guard_r;
                        exp_r    <= exp_r + EXP_ONE;
                        state    <= ROUND;
                    end else if (sig_r[SIG_W-2]) begin
                        state <= ROUND;
                    end else if (exp_r == '0) begin
                        out_word <= sat_pack(sign_r, '0, '0);
                        out_zero <= 1'b1;
`ifdef FP_NORM_FLAGS_EN
                        out_flags <= 3'b011;
`endif
                        state    <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Smallest normal exponent reached without a hidden bit: no denormals, flush
                    if (exp_r == EXP_ONE) begin
                        out_word <= sat_pack(sign_r, '0, '0);
                        out_zero <= 1'b1;
`ifdef FP_NORM_FLAGS_EN
                        out_flags <= 3'b011;
`endif
                        state    <= DONE;
                    end else begin
                        sig_r   <= {sig_r[SIG_W-2:0], guard_r};
                        guard_r <= 1'b0;
                        exp_r   <= exp_r - EXP_ONE;
                        if (sig_r[SIG_W-3]) begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    out_word <= sat_pack(sign_r, exp_rnd, frac_rnd);
                    out_zero <= 1'b0;
`ifdef FP_NORM_FLAGS_EN
                    out_flags <= {(exp_rnd >= EXP_ALL1), 1'b0, (guard_r | sticky_r)};
`endif
                    state    <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed self-checking bench for fp_norm_round_pack (flag checks when FP_NORM_FLAGS_EN is defined).
module tb_fp_norm_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_sig;
    logic        in_guard;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_zero;
`ifdef FP_NORM_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] r_word;
    logic        r_zero;
    logic [2:0]  r_flags;
    int          r_lat;

    fp_norm_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .in_guard  (in_guard),
        .in_sticky (in_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_zero  (out_zero)
`ifdef FP_NORM_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    always #5 clk = ~clk;

    // Handshake one operation in, then wait (bounded) for out_valid and capture the result
    task automatic start_op(input logic s, input logic [7:0] e, input logic [24:0] sg,
                            input logic g, input logic st);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_sign = s; in_exp = e; in_sig = sg; in_guard = g; in_sticky = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        r_lat = 0;
        while (!out_valid && r_lat < 100) begin
            @(posedge clk); #1; r_lat++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
        r_word = out_word;
        r_zero = out_zero;
`ifdef FP_NORM_FLAGS_EN
        r_flags = out_flags;
`else
        r_flags = 3'b000;
`endif
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 32'h0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b word=%h zero=%b required 1 0 00000000 0",
                     in_ready, out_valid, out_word, out_zero);
        end
    endtask

    task automatic test_normal();
        start_op(1'b0, 8'h7F, 25'h0800000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h3F800000 || r_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL one_word: word=%h zero=%b required 3f800000 0", r_word, r_zero);
        end
        n_checks++;
        if (r_lat !== 3) begin
            n_fail++;
            $display("FAIL one_latency: got %0d required 3", r_lat);
        end
        accept_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL out_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        start_op(1'b0, 8'h7F, 25'h1000000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h40000000 || r_lat !== 3) begin
            n_fail++;
            $display("FAIL carry_shift: word=%h lat=%0d required 40000000 3", r_word, r_lat);
        end
        accept_out();
        // Carry shift pushes a set LSB into guard; with tie and even result, no increment
        start_op(1'b1, 8'h80, 25'h1000001, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'hC0800000) begin
            n_fail++;
            $display("FAIL carry_tie_even: word=%h required c0800000", r_word);
        end
        accept_out();
    endtask

    task automatic test_long_shift();
        start_op(1'b0, 8'h7F, 25'h0000001, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h34000000) begin
            n_fail++;
            $display("FAIL shift23_word: word=%h required 34000000", r_word);
        end
        n_checks++;
        if (r_lat !== 26) begin
            n_fail++;
            $display("FAIL shift23_latency: got %0d required 26", r_lat);
        end
        accept_out();
    endtask

    task automatic test_rounding();
        start_op(1'b0, 8'h7F, 25'h0FFFFFF, 1'b1, 1'b0);
        n_checks++;
        if (r_word !== 32'h40000000) begin
            n_fail++;
            $display("FAIL round_carry: word=%h required 40000000", r_word);
        end
`ifdef FP_NORM_FLAGS_EN
        n_checks++;
        if (r_flags !== 3'b001) begin
            n_fail++;
            $display("FAIL round_carry_flags: got %b required 001", r_flags);
        end
`endif
        accept_out();
        start_op(1'b0, 8'h7F, 25'h0800000, 1'b1, 1'b0);
        n_checks++;
        if (r_word !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL tie_even_hold: word=%h required 3f800000", r_word);
        end
        accept_out();
        start_op(1'b0, 8'h7F, 25'h0800001, 1'b1, 1'b0);
        n_checks++;
        if (r_word !== 32'h3F800002) begin
            n_fail++;
            $display("FAIL tie_odd_up: word=%h required 3f800002", r_word);
        end
        accept_out();
        start_op(1'b0, 8'h7F, 25'h0800000, 1'b0, 1'b1);
        n_checks++;
        if (r_word !== 32'h3F800000) begin
            n_fail++;
            $display("FAIL sticky_only_down: word=%h required 3f800000", r_word);
        end
        accept_out();
    endtask

    task automatic test_overflow();
        start_op(1'b0, 8'hFE, 25'h1000000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h7F800000 || r_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_inf: word=%h zero=%b required 7f800000 0", r_word, r_zero);
        end
`ifdef FP_NORM_FLAGS_EN
        n_checks++;
        if (r_flags !== 3'b100) begin
            n_fail++;
            $display("FAIL overflow_flags: got %b required 100", r_flags);
        end
`endif
        accept_out();
    endtask

    task automatic test_zero_underflow();
        start_op(1'b1, 8'h55, 25'h0000000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h80000000 || r_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_zero: word=%h zero=%b required 80000000 1", r_word, r_zero);
        end
        accept_out();
        // exp 3 allows two left shifts before the minimum exponent forces a flush
        start_op(1'b1, 8'h03, 25'h0000001, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h80000000 || r_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_underflow: word=%h zero=%b required 80000000 1", r_word, r_zero);
        end
`ifdef FP_NORM_FLAGS_EN
        n_checks++;
        if (r_flags !== 3'b011) begin
            n_fail++;
            $display("FAIL underflow_flags: got %b required 011", r_flags);
        end
`endif
        accept_out();
        start_op(1'b0, 8'h00, 25'h0400000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h00000000 || r_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL exp0_flush: word=%h zero=%b required 00000000 1", r_word, r_zero);
        end
        accept_out();
    endtask

    task automatic test_backpressure();
        start_op(1'b1, 8'h81, 25'h0C00000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'hC0C00000) begin
            n_fail++;
            $display("FAIL bp_word: word=%h required c0c00000", r_word);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_word !== 32'hC0C00000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b word=%h in_ready=%b required 1 c0c00000 0",
                         i, out_valid, out_word, in_ready);
            end
        end
        accept_out();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        in_sign = 1'b0; in_exp = 8'h7F; in_sig = 25'h0000001; in_guard = 1'b0; in_sticky = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_shift: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) break;
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_partial: out_valid=%b required 0", out_valid);
        end
        start_op(1'b0, 8'h7F, 25'h0800000, 1'b0, 1'b0);
        n_checks++;
        if (r_word !== 32'h3F800000 || r_lat !== 3) begin
            n_fail++;
            $display("FAIL post_reset_op: word=%h lat=%0d required 3f800000 3", r_word, r_lat);
        end
        accept_out();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_sig = '0; in_guard = 1'b0; in_sticky = 1'b0;
        test_reset();
        test_normal();
        test_carry();
        test_long_shift();
        test_rounding();
        test_overflow();
        test_zero_underflow();
        test_backpressure();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
